// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 8x19 register file: core WB, FFT and crypto sources
// share one write port. Optional pending-destination scoreboard: REGFILE_ARB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W       = 19,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_wb_valid,
  input  logic [ADDR_W-1:0]   core_wb_addr,
  input  logic [DATA_W-1:0]   core_wb_data,
  output logic                core_wb_ready,
  input  logic                fft_wb_valid,
  input  logic [ADDR_W-1:0]   fft_wb_addr,
  input  logic [DATA_W-1:0]   fft_wb_data,
  output logic                fft_wb_ready,
  input  logic                cry_wb_valid,
  input  logic [ADDR_W-1:0]   cry_wb_addr,
  input  logic [DATA_W-1:0]   cry_wb_data,
  output logic                cry_wb_ready,
  input  logic                reserve_valid,
  input  logic [ADDR_W-1:0]   reserve_addr,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [1:0]          grant_id,
  output logic [NUM_REGS-1:0] pending_mask
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0] GID_NONE = 2'd0;
  localparam logic [1:0] GID_CORE = 2'd1;
  localparam logic [1:0] GID_FFT  = 2'd2;
  localparam logic [1:0] GID_CRY  = 2'd3;

  logic [CNT_W-1:0]  r_fft_cnt;
  logic [CNT_W-1:0]  r_cry_cnt;
  logic              r_rr_cry;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [1:0]        r_grant_id;

  logic              w_fft_starved;
  logic              w_cry_starved;
  logic [1:0]        w_sel;
  logic [1:0]        w_rr_pick;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  // Starved accelerators first, then the core, then round-robin among accelerators.
  always_comb begin
    w_fft_starved = fft_wb_valid && (r_fft_cnt == LIMIT);
    w_cry_starved = cry_wb_valid && (r_cry_cnt == LIMIT);
    w_rr_pick     = r_rr_cry ? GID_CRY : GID_FFT;
    w_sel         = GID_NONE;
    if (w_fft_starved && w_cry_starved) w_sel = w_rr_pick;
    else if (w_fft_starved)             w_sel = GID_FFT;
    else if (w_cry_starved)             w_sel = GID_CRY;
    else if (core_wb_valid)             w_sel = GID_CORE;
    else if (fft_wb_valid && cry_wb_valid) w_sel = w_rr_pick;
    else if (fft_wb_valid)              w_sel = GID_FFT;
    else if (cry_wb_valid)              w_sel = GID_CRY;
    if (!rst_n) w_sel = GID_NONE;
  end

  assign core_wb_ready = (w_sel == GID_CORE);
  assign fft_wb_ready  = (w_sel == GID_FFT);
  assign cry_wb_ready  = (w_sel == GID_CRY);

  always_comb begin
    w_wr_addr = core_wb_addr;
    w_wr_data = core_wb_data;
    case (w_sel)
      GID_FFT: begin
        w_wr_addr = fft_wb_addr;
        w_wr_data = fft_wb_data;
      end
      GID_CRY: begin
        w_wr_addr = cry_wb_addr;
        w_wr_data = cry_wb_data;
      end
      default: ;
    endcase
  end

  // Wait counters saturate at the limit; any idle or granted cycle clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fft_cnt <= '0;
      r_cry_cnt <= '0;
      r_rr_cry  <= 1'b0;
    end else begin
      if (!fft_wb_valid || fft_wb_ready) r_fft_cnt <= '0;
      else if (r_fft_cnt != LIMIT)       r_fft_cnt <= r_fft_cnt + CNT_W'(1);
      if (!cry_wb_valid || cry_wb_ready) r_cry_cnt <= '0;
      else if (r_cry_cnt != LIMIT)       r_cry_cnt <= r_cry_cnt + CNT_W'(1);
      if (fft_wb_ready)      r_rr_cry <= 1'b1;
      else if (cry_wb_ready) r_rr_cry <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_rd_addr   <= '0;
      r_wb_data   <= '0;
      r_grant_id  <= GID_NONE;
    end else begin
      r_reg_write <= (w_sel != GID_NONE);
      r_grant_id  <= w_sel;
      if (w_sel != GID_NONE) begin
        r_rd_addr <= w_wr_addr;
        r_wb_data <= w_wr_data;
      end
    end
  end

  assign reg_write = r_reg_write;
  assign rd_addr   = r_rd_addr;
  assign wb_data   = r_wb_data;
  assign grant_id  = r_grant_id;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_set;
  logic [NUM_REGS-1:0] w_pend_clr;

  // Accelerator write-backs retire a reservation; a same-cycle reserve wins.
  always_comb begin
    w_pend_set = reserve_valid ? (NUM_REGS'(1) << reserve_addr) : '0;
    w_pend_clr = (r_reg_write && r_grant_id[1]) ? (NUM_REGS'(1) << r_rd_addr) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
  end

  assign pending_mask = r_pending;
`else
  logic w_unused_reserve;
  assign w_unused_reserve = ^{reserve_valid, reserve_addr};
  assign pending_mask     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a cycle-level reference model predicts
// grants and writes; a negedge monitor checks presented writes and the pending mask.
module tb_regfile_wb_arbiter;
  localparam int DW  = 19;
  localparam int AW  = 3;
  localparam int NR  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_wb_valid, fft_wb_valid, cry_wb_valid;
  logic [AW-1:0] core_wb_addr, fft_wb_addr, cry_wb_addr;
  logic [DW-1:0] core_wb_data, fft_wb_data, cry_wb_data;
  logic          core_wb_ready, fft_wb_ready, cry_wb_ready;
  logic          reserve_valid;
  logic [AW-1:0] reserve_addr;
  logic          reg_write;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wb_data;
  logic [1:0]    grant_id;
  logic [NR-1:0] pending_mask;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_wb_valid(core_wb_valid), .core_wb_addr(core_wb_addr), .core_wb_data(core_wb_data),
    .core_wb_ready(core_wb_ready),
    .fft_wb_valid(fft_wb_valid), .fft_wb_addr(fft_wb_addr), .fft_wb_data(fft_wb_data),
    .fft_wb_ready(fft_wb_ready),
    .cry_wb_valid(cry_wb_valid), .cry_wb_addr(cry_wb_addr), .cry_wb_data(cry_wb_data),
    .cry_wb_ready(cry_wb_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .reg_write(reg_write), .rd_addr(rd_addr), .wb_data(wb_data),
    .grant_id(grant_id), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int gid; int addr; int data; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_addr = 0;
  int last_data = 0;

  // Reference model: index 1 core, 2 fft, 3 crypto.
  bit rv[1:3];
  int ra[1:3];
  int rd[1:3];
  int wt[1:3];
  int rr = 2;
  bit [NR-1:0] m_mask = '0;
  bit [NR-1:0] m_mask_nxt = '0;
  bit pw_acc = 1'b0;
  int pw_addr = 0;
  bit res_v = 1'b0;
  int res_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_grant();
    bit st2 = rv[2] && (wt[2] >= LIM);
    bit st3 = rv[3] && (wt[3] >= LIM);
    if (st2 && st3) return rr;
    if (st2) return 2;
    if (st3) return 3;
    if (rv[1]) return 1;
    if (rv[2] && rv[3]) return rr;
    if (rv[2]) return 2;
    if (rv[3]) return 3;
    return 0;
  endfunction

  function automatic int exp_mask();
`ifdef REGFILE_ARB_SCOREBOARD_EN
    return int'(m_mask);
`else
    return 0;
`endif
  endfunction

  task automatic req(input int s, input int a, input int d);
    rv[s] = 1'b1;
    ra[s] = a;
    rd[s] = d;
  endtask

  task automatic req_rand(input int s);
    req(s, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, (1 << DW) - 1)));
  endtask

  // One clock of stimulus: drive the requesters, compare readys, advance the model.
  task automatic cycle(output int g);
    bit [NR-1:0] nxt;
    bit was_v[1:3];
    @(posedge clk);
    #1;
    m_mask = m_mask_nxt;
    core_wb_valid = rv[1]; core_wb_addr = AW'(ra[1]); core_wb_data = DW'(rd[1]);
    fft_wb_valid  = rv[2]; fft_wb_addr  = AW'(ra[2]); fft_wb_data  = DW'(rd[2]);
    cry_wb_valid  = rv[3]; cry_wb_addr  = AW'(ra[3]); cry_wb_data  = DW'(rd[3]);
    reserve_valid = res_v; reserve_addr = AW'(res_a);
    #2;
    g = model_grant();
    check("core_ready", int'(core_wb_ready), int'(g == 1));
    check("fft_ready", int'(fft_wb_ready), int'(g == 2));
    check("cry_ready", int'(cry_wb_ready), int'(g == 3));
    nxt = m_mask;
    if (pw_acc) nxt[pw_addr] = 1'b0;
    if (res_v) nxt[res_a] = 1'b1;
    m_mask_nxt = nxt;
    pw_acc = (g >= 2);
    for (int s = 1; s <= 3; s++) was_v[s] = rv[s];
    if (g != 0) begin
      pw_addr = ra[g];
      q.push_back('{cyc: cyc + 1, gid: g, addr: ra[g], data: rd[g]});
      rv[g] = 1'b0;
      if (g >= 2) rr = (g == 2) ? 3 : 2;
    end
    for (int s = 2; s <= 3; s++)
      wt[s] = (was_v[s] && g != s) ? ((wt[s] + 1 > LIM) ? LIM : wt[s] + 1) : 0;
    res_v = 1'b0;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) cycle(g);
  endtask

  task automatic model_reset();
    for (int s = 1; s <= 3; s++) begin rv[s] = 1'b0; wt[s] = 0; ra[s] = 0; rd[s] = 0; end
    rr = 2; m_mask = '0; m_mask_nxt = '0; pw_acc = 1'b0; pw_addr = 0; res_v = 1'b0;
    q.delete();
    last_addr = 0; last_data = 0;
  endtask

  // Monitor: every presented write must match the oldest prediction at the right cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("pending_mask", int'(pending_mask), exp_mask());
      if (reg_write) begin
        if (q.size() == 0) check("spurious_write", 1, 0);
        else begin
          e = q.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("write_gid", int'(grant_id), e.gid);
          check("write_addr", int'(rd_addr), e.addr);
          check("write_data", int'(wb_data), e.data);
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("idle_gid", int'(grant_id), 0);
        check("hold_addr", int'(rd_addr), last_addr);
        check("hold_data", int'(wb_data), last_data);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          check("missing_write", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  int g;
  int seq[4];
  int fr[6];
  int cr[6];

  initial begin
    rst_n = 1'b0;
    core_wb_valid = 0; fft_wb_valid = 0; cry_wb_valid = 0;
    core_wb_addr = 0; fft_wb_addr = 0; cry_wb_addr = 0;
    core_wb_data = 0; fft_wb_data = 0; cry_wb_data = 0;
    reserve_valid = 0; reserve_addr = 0;
    model_reset();
    #2;
    core_wb_valid = 1'b1;
    #1;
    check("rst_reg_write", int'(reg_write), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wb_data", int'(wb_data), 0);
    check("rst_pending", int'(pending_mask), 0);
    check("rst_core_ready", int'(core_wb_ready), 0);
    core_wb_valid = 1'b0;
    #9 rst_n = 1'b1;
    idle(2);

    // Single core write.
    req(1, 1, 123);
    cycle(g);
    check("t1_core_ready", int'(core_wb_ready), 1);
    cycle(g);
    check("t1_reg_write", int'(reg_write), 1);
    check("t1_rd_addr", int'(rd_addr), 1);
    check("t1_wb_data", int'(wb_data), 123);
    check("t1_grant_id", int'(grant_id), 1);
    cycle(g);
    check("t1_write_done", int'(reg_write), 0);

    // Both accelerators continuously valid alternate starting at FFT.
    for (int i = 0; i < 4; i++) begin
      if (!rv[2]) req_rand(2);
      if (!rv[3]) req_rand(3);
      cycle(g);
      seq[i] = g;
    end
    for (int i = 0; i < 4; i++) check("t2_rr_seq", seq[i], (i % 2 == 0) ? 2 : 3);
    idle(4);

    // Continuous core traffic: FFT preempts after the wait limit.
    for (int i = 0; i < 6; i++) begin
      if (!rv[1]) req_rand(1);
      if (i == 0) req_rand(2);
      cycle(g);
      fr[i] = int'(fft_wb_ready);
      cr[i] = int'(core_wb_ready);
      if (i == 5) begin
        check("t3_fft_write", int'(reg_write), 1);
        check("t3_fft_gid", int'(grant_id), 2);
      end
    end
    for (int i = 0; i < 5; i++) check("t3_fft_ready", fr[i], int'(i == 4));
    check("t3_core_stalled", cr[4], 0);
    idle(3);

    // Reset in the cycle after a crypto transfer drops the pending write.
    req(3, 6, 777);
    cycle(g);
    check("t4_cry_ready", int'(cry_wb_ready), 1);
    @(posedge clk);
    #1;
    check("t4_write_pre", int'(reg_write), 1);
    rst_n = 1'b0;
    core_wb_valid = 1'b1; fft_wb_valid = 1'b1; cry_wb_valid = 1'b1;
    #1;
    check("t4_async_reg_write", int'(reg_write), 0);
    check("t4_rst_gid", int'(grant_id), 0);
    check("t4_rst_addr", int'(rd_addr), 0);
    check("t4_rst_data", int'(wb_data), 0);
    check("t4_rst_readys", int'({core_wb_ready, fft_wb_ready, cry_wb_ready}), 0);
    model_reset();
    core_wb_valid = 1'b0; fft_wb_valid = 1'b0; cry_wb_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    check("t4_no_write", int'(reg_write), 0);

    // Pending-destination scoreboard.
    res_v = 1'b1; res_a = 5;
    cycle(g);
    cycle(g);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    check("t5_reserve", int'(pending_mask), 32'h20);
`endif
    req(1, 5, 11);
    idle(3);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    check("t5_core_keeps", int'(pending_mask), 32'h20);
`endif
    req(3, 5, 22);
    idle(3);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    check("t5_cry_clears", int'(pending_mask), 0);
`endif
    req(2, 5, 33);
    cycle(g);
    res_v = 1'b1; res_a = 5;
    cycle(g);
    cycle(g);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    check("t5_set_wins", int'(pending_mask), 32'h20);
`endif
    idle(2);

    // Randomized traffic with phases of heavy core load.
    for (int i = 0; i < 1500; i++) begin
      int pc = ((i / 100) % 2 == 0) ? 60 : 100;
      if (!rv[1] && $urandom_range(0, 99) < pc) req_rand(1);
      if (!rv[2] && $urandom_range(0, 99) < 40) req_rand(2);
      if (!rv[3] && $urandom_range(0, 99) < 40) req_rand(3);
      if ($urandom_range(0, 99) < 20) begin
        res_v = 1'b1;
        res_a = int'($urandom_range(0, NR - 1));
      end
      cycle(g);
    end
    for (int s = 1; s <= 3; s++) rv[s] = 1'b0;
    idle(20);
    for (int s = 1; s <= 3; s++) rv[s] = 1'b0;
    idle(3);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 8×19-bit register file. Three write-back sources share the regfile's single write port: core pipeline WB, FFT accelerator, crypto accelerator. The block grants one source per cycle over valid/ready handshakes and registers the winner onto `reg_write`/`rd_addr`/`wb_data`. Anti-starvation logic bounds accelerator wait while the core keeps default priority.

## Interface
- `DATA_W`, 19, write data width
- `ADDR_W`, 3, register address width
- `NUM_REGS`, 8, register count (2**ADDR_W)
- `STARVE_LIMIT`, 4, accelerator wait cycles before it preempts the core (1..15)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `core_wb_valid`  in  1  core write-back request
- `core_wb_addr`  in  ADDR_W  core destination
- `core_wb_data`  in  DATA_W  core data
- `core_wb_ready`  out  1  core request accepted this cycle
- `fft_wb_valid` / `fft_wb_addr` / `fft_wb_data` / `fft_wb_ready`  in/in/in/out  1/ADDR_W/DATA_W/1  FFT write-back handshake
- `cry_wb_valid` / `cry_wb_addr` / `cry_wb_data` / `cry_wb_ready`  in/in/in/out  1/ADDR_W/DATA_W/1  crypto write-back handshake
- `reserve_valid`  in  1  issue stage reserves an accelerator destination
- `reserve_addr`  in  ADDR_W  reserved register
- `reg_write`  out  1  regfile write enable
- `rd_addr`  out  ADDR_W  regfile write address
- `wb_data`  out  DATA_W  regfile write data
- `grant_id`  out  2  source of the current write: 0 none, 1 core, 2 fft, 3 crypto
- `pending_mask`  out  NUM_REGS  registers awaiting accelerator write-back

## Operation
- Readys are combinational from the valids and registered state. At most one ready is high per cycle. A transfer is valid&&ready.
- Grant order per cycle:
  - Any accelerator whose wait counter equals `STARVE_LIMIT` wins. If both are starved, the round-robin pointer decides.
  - Otherwise the core wins if valid.
  - Otherwise, among valid accelerators, the round-robin pointer decides.
- Round-robin pointer: reset value points at FFT. After any accelerator transfer, it points at the other accelerator. Core grants leave it unchanged.
- Wait counters, one per accelerator:
  - Increment when valid&&!ready, saturating at `STARVE_LIMIT`.
  - Clear on transfer or when valid is low.
- Requesters hold addr/data stable while valid&&!ready. The arbiter does not check this.
- No bypass or merging. Two sources targeting the same address are written in grant order.

## Timing
- Transfer in cycle N drives `reg_write`=1, `rd_addr`, `wb_data` and `grant_id` in cycle N+1, for exactly one cycle.
- Back-to-back transfers produce back-to-back writes. Throughput is 1 write/cycle.
- With no transfer: `reg_write`=0 and `grant_id`=0. `rd_addr` and `wb_data` hold their last values.
- Reset values: `reg_write` 0, `rd_addr` 0, `wb_data` 0, `grant_id` 0, `pending_mask` 0, counters 0, pointer FFT.
- Ready outputs are 0 while `rst_n` is low.
- Reset mid-operation: a registered but not yet presented write is dropped, and `reg_write` falls immediately (async).
- Worst-case accelerator wait with a continuously valid core: `STARVE_LIMIT`+1 cycles from valid to ready.

## Configuration
- Macro: `REGFILE_ARB_SCOREBOARD_EN`.
- Defined:
  - `reserve_valid` sets `pending_mask[reserve_addr]` at the next edge.
  - A presented write with `grant_id`=2 or 3 clears `pending_mask[rd_addr]` at the next edge. Core writes never clear bits.
  - If the same bit is set and cleared in the same cycle, set wins.
- Undefined: `pending_mask` is tied to 0 and the reserve inputs are ignored. The port list is identical in both builds.

## Test plan
- Reset, then a single core request (addr 1, data 123): `core_wb_ready`=1 that cycle; next cycle `reg_write`=1, `rd_addr`=1, `wb_data`=123, `grant_id`=1; then `reg_write`=0.
- FFT and crypto both valid, core idle, 4 cycles: grants alternate fft, cry, fft, cry starting at FFT; `grant_id` sequence 2,3,2,3.
- Core valid every cycle and FFT valid from cycle 0, `STARVE_LIMIT`=4: `fft_wb_ready` is 0 in cycles 0–3 and 1 in cycle 4 (core stalled that cycle), and the FFT write appears in cycle 5.
- Assert `rst_n` low in the cycle after a crypto transfer: `reg_write` goes to 0 asynchronously, and after release all outputs hold their reset values and no write occurs.
- With `REGFILE_ARB_SCOREBOARD_EN`: reserve addr 5 gives `pending_mask`=0x20. A core write to 5 leaves it 0x20. A crypto write to 5 clears it to 0x00 one cycle after `reg_write`. Simultaneous reserve 5 and FFT write-back to 5 leaves the bit set.
